// File: rtl/lif_sched_pkg.sv
// Shared types, constants and the saturating adder for the LIF sweep scheduler.
package lif_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_COMMIT = 2'd2,
    S_DONE   = 2'd3
  } sched_state_e;

  localparam int NUM_NEURONS_DEF = 4;
  localparam int ID_W            = $clog2(NUM_NEURONS_DEF);
  localparam int SAT_W           = 16;
  localparam logic [1:0] REFRACT_INIT = 2'd3;

  // Adds two values and clamps the result to 2^w-1 (operands zero-extended to SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int               w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/lif_sweep_scheduler_core.sv
// Combinational leaky integrate-and-fire update: leak, integrate, threshold compare.
module lif_update_core
  import lif_sched_pkg::*;
#(
  parameter int STATE_W    = 6,
  parameter int LEAK_SHIFT = 1
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [STATE_W-1:0] i_pending,
  input  logic [STATE_W-1:0] i_thr,
  output logic [STATE_W-1:0] o_nxt,
  output logic               o_spk
);

  logic [STATE_W-1:0] w_leaked;

  assign w_leaked = i_state >> LEAK_SHIFT;
  assign o_nxt    = STATE_W'(sat_add(SAT_W'(i_pending), SAT_W'(w_leaked), STATE_W));
  assign o_spk    = (o_nxt >= i_thr);

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update core per tick.
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_sweep_scheduler
  import lif_sched_pkg::*;
#(
  parameter int NUM_NEURONS    = 4,
  parameter int STATE_W        = 6,
  parameter int LEAK_SHIFT     = 1,
  parameter int THRESH_DEFAULT = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_tick,
  input  logic                           i_stim_valid,
  output logic                           o_stim_ready,
  input  logic [$clog2(NUM_NEURONS)-1:0] i_stim_id,
  input  logic [STATE_W-1:0]             i_stim_current,
  input  logic                           i_cfg_we,
  input  logic [$clog2(NUM_NEURONS)-1:0] i_cfg_addr,
  input  logic [STATE_W-1:0]             i_cfg_data,
  output logic                           o_spike_valid,
  input  logic                           i_spike_ready,
  output logic [$clog2(NUM_NEURONS)-1:0] o_spike_id,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_tick_overrun
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [STATE_W-1:0] THR_INIT = STATE_W'(THRESH_DEFAULT);

  sched_state_e       r_fsm;
  logic [IDX_W-1:0]   r_idx;
  logic [STATE_W-1:0] r_mem  [NUM_NEURONS];
  logic [STATE_W-1:0] r_pend [NUM_NEURONS];
  logic [STATE_W-1:0] r_thr  [NUM_NEURONS];
  logic [STATE_W-1:0] r_cur_state;
  logic [STATE_W-1:0] r_cur_pend;
  logic [STATE_W-1:0] r_cur_thr;
  logic               r_spike_valid;
  logic [IDX_W-1:0]   r_spike_id;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;

  logic [STATE_W-1:0] w_core_nxt;
  logic               w_core_spk;
  logic [STATE_W-1:0] w_nxt;
  logic               w_spk;
  logic               w_refr;
  logic               w_commit;
  logic               w_stim_fire;
  logic [STATE_W-1:0] w_pend_plus;

  lif_update_core #(
    .STATE_W    (STATE_W),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_core (
    .i_state   (r_cur_state),
    .i_pending (r_cur_pend),
    .i_thr     (r_cur_thr),
    .o_nxt     (w_core_nxt),
    .o_spk     (w_core_spk)
  );

  // The entry under read-clear is the only one that cannot take stimulus.
  assign o_stim_ready = !reset && !((r_fsm == S_COMMIT) && (i_stim_id == r_idx));
  assign w_stim_fire  = i_stim_valid && o_stim_ready;
  assign w_pend_plus  = STATE_W'(sat_add(SAT_W'(r_pend[i_stim_id]), SAT_W'(i_stim_current), STATE_W));

  assign w_spk    = w_core_spk && !w_refr;
  assign w_nxt    = w_refr ? '0 : w_core_nxt;
  assign w_commit = (r_fsm == S_COMMIT) && (!w_spk || !r_spike_valid || i_spike_ready);

`ifdef LIF_REFRACTORY_EN
  logic [1:0] r_ref [NUM_NEURONS];
  logic [1:0] r_cur_ref;

  assign w_refr = (r_cur_ref != 2'd0);

  // Refractory counters: latched with the neuron, counted down on each silenced commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_ref <= 2'd0;
      for (int i = 0; i < NUM_NEURONS; i++) r_ref[i] <= 2'd0;
    end else if (r_fsm == S_READ) begin
      r_cur_ref <= r_ref[r_idx];
    end else if (w_commit) begin
      if (w_refr) r_ref[r_idx] <= r_cur_ref - 2'd1;
      else if (w_core_spk) r_ref[r_idx] <= REFRACT_INIT;
    end
  end
`else
  assign w_refr = 1'b0;
`endif

  // Sweep FSM, neuron storage, stimulus accumulation and spike holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm         <= S_IDLE;
      r_idx         <= '0;
      r_cur_state   <= '0;
      r_cur_pend    <= '0;
      r_cur_thr     <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i]  <= '0;
        r_pend[i] <= '0;
        r_thr[i]  <= THR_INIT;
      end
    end else begin
      if (r_spike_valid && i_spike_ready) r_spike_valid <= 1'b0;
      if (w_stim_fire) r_pend[i_stim_id] <= w_pend_plus;
      if (i_tick && r_busy) r_overrun <= 1'b1;
      case (r_fsm)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_cfg_we) r_thr[i_cfg_addr] <= i_cfg_data;
          if (i_tick) begin
            r_fsm  <= S_READ;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_READ: begin
          // Fold in a same-cycle stimulus so it is not lost by the coming clear.
          r_cur_state <= r_mem[r_idx];
          r_cur_pend  <= (w_stim_fire && (i_stim_id == r_idx)) ? w_pend_plus : r_pend[r_idx];
          r_cur_thr   <= r_thr[r_idx];
          r_fsm       <= S_COMMIT;
        end
        S_COMMIT: begin
          if (w_commit) begin
            r_mem[r_idx]  <= w_spk ? '0 : w_nxt;
            r_pend[r_idx] <= '0;
            if (w_spk) begin
              r_spike_valid <= 1'b1;
              r_spike_id    <= r_idx;
            end
            if (r_idx == IDX_W'(NUM_NEURONS - 1)) begin
              r_fsm  <= S_DONE;
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_fsm <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign o_spike_valid  = r_spike_valid;
  assign o_spike_id     = r_spike_id;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_tick_overrun = r_overrun;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench for lif_sweep_scheduler (N=4, STATE_W=6, LEAK_SHIFT=1, THRESH_DEFAULT=32).
module tb_lif_sweep_scheduler;

  localparam int N    = 4;
  localparam int MAXV = 63;
  localparam int MAXK = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       stim_valid = 1'b0;
  logic       stim_ready;
  logic [1:0] stim_id = 2'd0;
  logic [5:0] stim_current = 6'd0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [5:0] cfg_data = 6'd0;
  logic       spike_valid;
  logic       spike_ready = 1'b1;
  logic [1:0] spike_id;
  logic       busy;
  logic       done;
  logic       tick_overrun;

  int n_checks = 0;
  int n_errors = 0;

  int m_mem[N], m_pend[N], m_thr[N], m_ref[N];
  int exp_spikes[$];
  int obs_spikes[$];
  int obs_done_k;
  bit obs_busy[MAXK];
  bit obs_valid[MAXK];
  int obs_id[MAXK];

  lif_sweep_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .i_tick         (tick),
    .i_stim_valid   (stim_valid),
    .o_stim_ready   (stim_ready),
    .i_stim_id      (stim_id),
    .i_stim_current (stim_current),
    .i_cfg_we       (cfg_we),
    .i_cfg_addr     (cfg_addr),
    .i_cfg_data     (cfg_data),
    .o_spike_valid  (spike_valid),
    .i_spike_ready  (spike_ready),
    .o_spike_id     (spike_id),
    .o_busy         (busy),
    .o_done         (done),
    .o_tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: one whole sweep computed from the neuron rules.
  function automatic void model_sweep();
    int nxt;
    exp_spikes.delete();
    for (int i = 0; i < N; i++) begin
      if (m_ref[i] > 0) begin
        m_ref[i]--;
        m_mem[i]  = 0;
        m_pend[i] = 0;
      end else begin
        nxt = m_pend[i] + m_mem[i] / 2;
        if (nxt > MAXV) nxt = MAXV;
        if (nxt >= m_thr[i]) begin
          exp_spikes.push_back(i);
          m_mem[i] = 0;
`ifdef LIF_REFRACTORY_EN
          m_ref[i] = 3;
`endif
        end else begin
          m_mem[i] = nxt;
        end
        m_pend[i] = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0; m_pend[i] = 0; m_thr[i] = 32; m_ref[i] = 0;
    end
  endfunction

  function automatic bit q_equal();
    if (obs_spikes.size() != exp_spikes.size()) return 1'b0;
    for (int i = 0; i < obs_spikes.size(); i++)
      if (obs_spikes[i] != exp_spikes[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; stim_valid = 1'b0; cfg_we = 1'b0; spike_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_stim(input int id, input int cur);
    int w;
    @(negedge clk);
    stim_valid = 1'b1; stim_id = 2'(id); stim_current = 6'(cur);
    w = 0;
    while (!stim_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!stim_ready) begin
      n_checks++; n_errors++;
      $display("FAIL stim_handshake: stim_ready=%0b required 1", stim_ready);
    end else begin
      m_pend[id] = (m_pend[id] + cur > MAXV) ? MAXV : m_pend[id] + cur;
    end
    @(negedge clk);
    stim_valid = 1'b0;
  endtask

  task automatic drive_cfg(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 6'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    m_thr[a] = d;
  endtask

  // ready_mode: 0 always ready, 1 random, 2 held low until k=30.
  // cfg_mode: 0 none, 1 cfg together with tick, 2 cfg at k=3 (mid-sweep).
  task automatic run_sweep(input int ready_mode, input int cfg_mode, input int ca, input int cd);
    bit seen_done;
    seen_done = 1'b0;
    obs_spikes.delete();
    obs_done_k = -1;
    for (int j = 0; j < MAXK; j++) begin
      obs_busy[j] = 1'b0; obs_valid[j] = 1'b0; obs_id[j] = 0;
    end
    @(negedge clk);
    tick = 1'b1;
    if (cfg_mode == 1) begin
      cfg_we = 1'b1; cfg_addr = 2'(ca); cfg_data = 6'(cd);
    end
    for (int k = 1; k < MAXK; k++) begin
      @(negedge clk);
      tick = 1'b0;
      if (cfg_mode == 1) cfg_we = 1'b0;
      if (cfg_mode == 2) begin
        cfg_we = (k == 3); cfg_addr = 2'(ca); cfg_data = 6'(cd);
      end
      case (ready_mode)
        0:       spike_ready = 1'b1;
        1:       spike_ready = seen_done ? 1'b1 : 1'($urandom_range(1, 0));
        default: spike_ready = (k >= 30);
      endcase
      obs_busy[k]  = busy;
      obs_valid[k] = spike_valid;
      obs_id[k]    = int'(spike_id);
      if (spike_valid && spike_ready) obs_spikes.push_back(int'(spike_id));
      if (done && obs_done_k < 0) begin
        obs_done_k = k;
        seen_done  = 1'b1;
      end
      if (seen_done && !spike_valid) break;
    end
    cfg_we = 1'b0;
    spike_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (stim_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_stim_ready: got %0b required 0", stim_ready);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({spike_valid, spike_id, busy, done, tick_overrun} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%0b id=%0d busy=%0b done=%0b ovr=%0b required all 0",
               spike_valid, spike_id, busy, done, tick_overrun);
    end
    n_checks++;
    if (stim_ready !== 1'b1) begin
      n_errors++; $display("FAIL idle_stim_ready: got %0b required 1", stim_ready);
    end
  endtask

  task automatic test_idle_sweep();
    model_sweep();
    run_sweep(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (obs_busy[k] !== 1'b1) begin
        n_errors++; $display("FAIL idle_busy k=%0d: got %0b required 1", k, obs_busy[k]);
      end
    end
    n_checks++;
    if (obs_busy[9] !== 1'b0) begin
      n_errors++; $display("FAIL idle_busy_end: got %0b required 0", obs_busy[9]);
    end
    n_checks++;
    if (obs_done_k != 9) begin
      n_errors++; $display("FAIL idle_done_cycle: got %0d required 9", obs_done_k);
    end
    n_checks++;
    if (obs_spikes.size() != 0) begin
      n_errors++; $display("FAIL idle_no_spike: got %0d events required 0", obs_spikes.size());
    end
  endtask

  task automatic test_single_spike();
    int first_k;
    drive_stim(2, 40);
    model_sweep();
    run_sweep(0, 0, 0, 0);
    first_k = -1;
    for (int k = 1; k < MAXK; k++)
      if (obs_valid[k] && first_k < 0) first_k = k;
    n_checks++;
    if (first_k != 7 || obs_id[7] != 2) begin
      n_errors++; $display("FAIL single_spike_timing: first valid k=%0d id=%0d required k=7 id=2", first_k, obs_id[7]);
    end
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL single_spike_events: got %p required %p", obs_spikes, exp_spikes);
    end
    model_sweep();
    run_sweep(0, 0, 0, 0);
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL single_spike_after: got %p required %p", obs_spikes, exp_spikes);
    end
  endtask

  task automatic test_integration();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      drive_stim(0, 20);
      model_sweep();
      run_sweep(0, 0, 0, 0);
      n_checks++;
      if (!q_equal()) begin
        n_errors++; $display("FAIL integrate_sweep%0d: got %p required %p", s, obs_spikes, exp_spikes);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_stim(1, 40);
    drive_stim(3, 40);
    model_sweep();
    run_sweep(2, 0, 0, 0);
    n_checks++;
    if (obs_busy[29] !== 1'b1 || obs_valid[29] !== 1'b1 || obs_id[29] != 1) begin
      n_errors++;
      $display("FAIL stall_hold: busy=%0b valid=%0b id=%0d required 1 1 1", obs_busy[29], obs_valid[29], obs_id[29]);
    end
    n_checks++;
    if (obs_done_k != 31) begin
      n_errors++; $display("FAIL stall_done_cycle: got %0d required 31", obs_done_k);
    end
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL stall_events: got %p required %p", obs_spikes, exp_spikes);
    end
  endtask

  task automatic test_saturation_cfg();
    do_reset();
    drive_stim(0, 63);
    drive_stim(0, 63);
    drive_cfg(0, 63);
    model_sweep();
    run_sweep(0, 0, 0, 0);
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL sat_pending_spike: got %p required %p", obs_spikes, exp_spikes);
    end
    model_sweep();
    run_sweep(0, 2, 1, 1);
    drive_stim(1, 10);
    model_sweep();
    run_sweep(0, 0, 0, 0);
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL cfg_busy_ignored: got %p required %p", obs_spikes, exp_spikes);
    end
    drive_stim(2, 5);
    m_thr[2] = 5;
    model_sweep();
    run_sweep(0, 1, 2, 5);
    n_checks++;
    if (!q_equal()) begin
      n_errors++; $display("FAIL cfg_with_tick: got %p required %p", obs_spikes, exp_spikes);
    end
  endtask

  task automatic test_overrun_reset();
    int dk;
    do_reset();
    dk = -1;
    @(negedge clk);
    tick = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tick = (k == 3);
      if (done && dk < 0) dk = k;
      if (k == 5) begin
        n_checks++;
        if (tick_overrun !== 1'b1) begin
          n_errors++; $display("FAIL overrun_set: got %0b required 1", tick_overrun);
        end
      end
    end
    model_sweep();
    n_checks++;
    if (dk != 9 || busy !== 1'b0 || tick_overrun !== 1'b1) begin
      n_errors++; $display("FAIL overrun_no_restart: done k=%0d busy=%0b ovr=%0b required 9 0 1", dk, busy, tick_overrun);
    end
    drive_stim(0, 50);
    @(negedge clk);
    spike_ready = 1'b0;
    tick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tick = 1'b0;
    end
    n_checks++;
    if (spike_valid !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL midsweep_pre: valid=%0b busy=%0b required 1 1", spike_valid, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || spike_valid !== 1'b0 || tick_overrun !== 1'b0) begin
      n_errors++; $display("FAIL midsweep_reset: busy=%0b valid=%0b ovr=%0b required 0 0 0", busy, spike_valid, tick_overrun);
    end
    reset = 1'b0;
    spike_ready = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int ns;
    int ca, cd, mode;
    do_reset();
    for (int r = 0; r < 16; r++) begin
      ns = $urandom_range(4, 0);
      for (int s = 0; s < ns; s++) drive_stim($urandom_range(3, 0), $urandom_range(63, 0));
      if ($urandom_range(3, 0) == 0) drive_cfg($urandom_range(3, 0), $urandom_range(63, 16));
      mode = ($urandom_range(3, 0) == 0) ? 1 : 0;
      ca = $urandom_range(3, 0);
      cd = $urandom_range(63, 16);
      if (mode == 1) m_thr[ca] = cd;
      model_sweep();
      run_sweep(1, mode, ca, cd);
      n_checks++;
      if (obs_done_k < 0) begin
        n_errors++; $display("FAIL random_done round%0d: no done within bound", r);
      end
      n_checks++;
      if (!q_equal()) begin
        n_errors++; $display("FAIL random_events round%0d: got %p required %p", r, obs_spikes, exp_spikes);
      end
    end
  endtask

`ifdef LIF_REFRACTORY_EN
  task automatic test_refractory();
    do_reset();
    for (int s = 0; s < 5; s++) begin
      drive_stim(0, 63);
      model_sweep();
      run_sweep(0, 0, 0, 0);
      n_checks++;
      if (!q_equal() || obs_spikes.size() != ((s == 0 || s == 4) ? 1 : 0)) begin
        n_errors++; $display("FAIL refractory_sweep%0d: got %p required %p", s, obs_spikes, exp_spikes);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_idle_sweep();
    test_single_spike();
    test_integration();
    test_backpressure();
    test_saturation_cfg();
    test_overrun_reset();
    test_random();
`ifdef LIF_REFRACTORY_EN
    test_refractory();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
